// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states, latched-operation context and counter sizing.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Context captured at accept time and used when writing the result.
  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
  } ctx_t;

  function automatic int unsigned iter_bits(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Magnitude/sign split of a possibly-signed value; i_force_neg turns it
// into an unconditional two's-complement negate for result correction.
module muldiv_abs #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_signed,
  input  logic         i_force_neg,
  output logic [W-1:0] o_mag_c,
  output logic         o_sign_c
);

  assign o_sign_c = i_signed & i_val[W-1];
  assign o_mag_c  = (o_sign_c | i_force_neg) ? W'('0 - i_val) : i_val;

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with private HI/LO,
// one shift-add / restoring-subtract step per RUN cycle.
module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned CW = iter_bits(WIDTH);

  state_t               r_state, w_state_nxt;
  logic                 r_busy, r_done;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_opd;
  ctx_t                 r_ctx;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_div_zero, r_zero, r_neg;

  logic                 w_accept, w_direct, w_last, w_signed_op, w_is_div_op;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic                 w_sgn_a, w_sgn_b;
  logic [WIDTH:0]       w_sum, w_shift;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_prod_fin;
  logic [WIDTH-1:0]     w_quo_nxt, w_rem_nxt, w_quo_fin, w_rem_fin;
  logic                 w_unused_sgn_p, w_unused_sgn_q, w_unused_sgn_r;

  assign w_signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign w_accept    = start && !r_busy && (op <= OP_MTLO);
  assign w_direct    = (op == OP_MTHI) || (op == OP_MTLO) || (w_is_div_op && (b == '0));
  assign w_last      = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));

  muldiv_abs #(.W(WIDTH)) u_abs_a (
    .i_val(a), .i_signed(w_signed_op), .i_force_neg(1'b0),
    .o_mag_c(w_mag_a), .o_sign_c(w_sgn_a)
  );
  muldiv_abs #(.W(WIDTH)) u_abs_b (
    .i_val(b), .i_signed(w_signed_op), .i_force_neg(1'b0),
    .o_mag_c(w_mag_b), .o_sign_c(w_sgn_b)
  );

  // One multiply step: add multiplicand into the upper half if LSB set, then shift right.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opd};
  assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

  // One restoring-divide step on a WIDTH+1 bit partial remainder.
  assign w_shift   = {r_rem, r_acc[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_opd});
  assign w_rem_nxt = w_ge ? WIDTH'(w_shift - {1'b0, r_opd}) : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_acc[WIDTH-2:0], w_ge};

  muldiv_abs #(.W(2*WIDTH)) u_neg_prod (
    .i_val(w_mul_nxt), .i_signed(1'b0), .i_force_neg(r_ctx.neg_res),
    .o_mag_c(w_prod_fin), .o_sign_c(w_unused_sgn_p)
  );
  muldiv_abs #(.W(WIDTH)) u_neg_quo (
    .i_val(w_quo_nxt), .i_signed(1'b0), .i_force_neg(r_ctx.neg_res),
    .o_mag_c(w_quo_fin), .o_sign_c(w_unused_sgn_q)
  );
  muldiv_abs #(.W(WIDTH)) u_neg_rem (
    .i_val(w_rem_nxt), .i_signed(1'b0), .i_force_neg(r_ctx.neg_rem),
    .o_mag_c(w_rem_fin), .o_sign_c(w_unused_sgn_r)
  );

  // State register with registered busy/done decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (w_accept) w_state_nxt = w_direct ? DONE : RUN;
      end
      RUN:     if (w_last) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result/flag write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_opd      <= '0;
      r_ctx      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
      r_zero     <= 1'b1;
      r_neg      <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
      case (op)
        OP_MULT, OP_MULTU: begin
          r_acc <= {WIDTH'(0), w_mag_b};
          r_opd <= w_mag_a;
          r_ctx <= ctx_t'{is_div: 1'b0, neg_res: w_sgn_a ^ w_sgn_b, neg_rem: 1'b0};
        end
        OP_DIV, OP_DIVU: begin
          r_acc <= {WIDTH'(0), w_mag_a};
          r_opd <= w_mag_b;
          r_ctx <= ctx_t'{is_div: 1'b1, neg_res: w_sgn_a ^ w_sgn_b, neg_rem: w_sgn_a};
          if (b == '0) begin
            r_div_zero <= 1'b1;
            r_zero     <= ({r_hi, r_lo} == '0);
            r_neg      <= r_lo[WIDTH-1];
          end
        end
        OP_MTHI: begin
          r_hi   <= a;
          r_zero <= (a == '0) && (r_lo == '0);
          r_neg  <= 1'b0;
        end
        OP_MTLO: begin
          r_lo   <= a;
          r_zero <= (a == '0) && (r_hi == '0);
          r_neg  <= 1'b0;
        end
        default: ;
      endcase
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_ctx.is_div) begin
        r_acc[WIDTH-1:0] <= w_quo_nxt;
        r_rem            <= w_rem_nxt;
      end else begin
        r_acc <= w_mul_nxt;
      end
      if (w_last) begin
        if (r_ctx.is_div) begin
          r_lo   <= w_quo_fin;
          r_hi   <= w_rem_fin;
          r_zero <= ({w_rem_fin, w_quo_fin} == '0);
          r_neg  <= w_quo_fin[WIDTH-1];
        end else begin
          {r_hi, r_lo} <= w_prod_fin;
          r_zero       <= (w_prod_fin == '0);
          r_neg        <= w_prod_fin[2*WIDTH-1];
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign zero     = r_zero;
  assign negative = r_neg;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: an arithmetic reference model checked every
// cycle, plus literal expectations for the hand-worked cases.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero, zero, negative;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_start = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: what {hi,lo} must become for an op, from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] h,
                                             input logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = {h, l};
    case (o)
      3'd0: res = 64'(sx * sy);
      3'd1: res = {32'd0, x} * {32'd0, y};
      3'd2: if (y != 0) begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
      3'd3: if (y != 0) res = {x % y, x / y};
      3'd4: res = {x, l};
      3'd5: res = {h, x};
      default: ;
    endcase
    return res;
  endfunction

  logic [31:0] m_hi, m_lo;
  logic        m_dz, m_zero, m_neg, m_done, m_valid = 1'b0;
  int          m_run;
  logic [63:0] p_res;
  logic [2:0]  p_op;

  // Model: a mul/div occupies 32 cycles then publishes; direct ops publish at once.
  always @(posedge clk) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_dz = 0; m_zero = 1; m_neg = 0; m_done = 0; m_run = 0;
      m_valid = 1'b1;
    end else begin
      m_done = 0;
      if (m_run > 0) begin
        m_run--;
        if (m_run == 0) begin
          {m_hi, m_lo} = p_res;
          m_zero = (p_res == 0);
          m_neg  = (p_op <= 3'd1) ? p_res[63] : p_res[31];
          m_done = 1;
        end
      end else if (start && op <= 3'd5) begin
        p_res = ref_result(op, a, b, m_hi, m_lo);
        p_op  = op;
        m_dz  = (op == 3'd2 || op == 3'd3) && (b == 0);
        if (op >= 3'd4 || m_dz) begin
          {m_hi, m_lo} = p_res;
          m_zero = (p_res == 0);
          m_neg  = (op >= 3'd4) ? 1'b0 : p_res[31];
          m_done = 1;
        end else begin
          m_run = 32;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 64'(busy), 64'(m_run > 0));
      check("done", 64'(done), 64'(m_done));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("div_zero", 64'(div_zero), 64'(m_dz));
      check("zero", 64'(zero), 64'(m_zero));
      check("negative", 64'(negative), 64'(m_neg));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    t_start = cyc;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, 64'(cyc - t_start), 64'(exp_lat));
  endtask

  task automatic expect_res(input string nm, input logic [31:0] eh, input logic [31:0] el,
                            input logic en);
    check({nm, "_hi"}, 64'(hi), 64'(eh));
    check({nm, "_lo"}, 64'(lo), 64'(el));
    check({nm, "_neg"}, 64'(negative), 64'(en));
  endtask

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_zero", 64'(zero), 64'h1);
    check("rst_busy", 64'(busy), 64'h0);

    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult", 33);
    expect_res("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);  // issued in the DONE cycle
    wait_done("multu", 33);
    expect_res("multu", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 33);
    expect_res("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);

    issue(3'd3, 32'd7, 32'd2);
    wait_done("divu", 33);
    expect_res("divu", 32'd1, 32'd3, 1'b0);

    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_negdvs", 33);
    expect_res("div_negdvs", 32'd1, 32'hFFFF_FFFD, 1'b1);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 33);
    expect_res("div_ovf", 32'h0, 32'h8000_0000, 1'b1);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 33);
    expect_res("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);

    issue(3'd4, 32'h1234, 32'd0);
    wait_done("mthi", 1);
    issue(3'd5, 32'h0, 32'd0);
    wait_done("mtlo", 1);
    issue(3'd3, 32'd5, 32'd0);
    wait_done("divz", 1);
    expect_res("divz", 32'h1234, 32'h0, 1'b0);
    check("divz_flag", 64'(div_zero), 64'h1);
    check("divz_zero", 64'(zero), 64'h0);

    @(negedge clk);
    issue(3'd6, 32'h5, 32'h5);  // reserved: ignored
    repeat (3) @(negedge clk);
    check("rsvd_busy", 64'(busy), 64'h0);
    check("rsvd_hi", 64'(hi), 64'h1234);

    issue(3'd0, 32'd3, 32'hFFFF_FFFB);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;  // cycle t+5, busy: dropped
    @(negedge clk);
    start = 1'b0;
    wait_done("stall", 33);
    expect_res("stall", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);

    issue(3'd1, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 64'(busy), 64'h0);
    check("mrst_hi", 64'(hi), 64'h0);
    check("mrst_lo", 64'(lo), 64'h0);
    check("mrst_zero", 64'(zero), 64'h1);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("mrst_nodone", 64'(ndone), 64'h0);

    issue(3'd5, 32'h0, 32'h0);
    wait_done("mtlo0", 1);
    check("mtlo0_zero", 64'(zero), 64'h1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

- Parametrised, multi-cycle multiply/divide unit with its own HI/LO register pair.
- Sits beside the single-cycle ALU in the MIPS-54 execute stage and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Uses one iterative shift-add / restoring-subtract datapath.
- A start/busy/done handshake lets the control unit stall the pipeline while an operation runs.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO source
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse; hi/lo/flags valid in the same cycle
- div_zero  out  1  registered; set by DIV/DIVU with b=0, cleared by any other accepted op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- zero  out  1  registered, {hi,lo}==0 after the last accepted op
- negative  out  1  registered, MSB of hi after MULT/MULTU, MSB of lo after DIV/DIVU, 0 otherwise

## Operation
- States:
  - IDLE: accept a start.
  - RUN: WIDTH iterations.
  - DONE: one cycle; done=1.
- Accepted start: start=1, busy=0, and op not reserved. A reserved op is ignored, with no state change.
- On accept, a and b are latched. For signed ops, both are converted to magnitude plus sign. Later changes on a/b are ignored.
- MULT/MULTU:
  - Shift-add of magnitudes over WIDTH cycles into a 2·WIDTH accumulator.
  - MULT negates the product if the operand signs differ.
  - {hi,lo} = product.
- DIV/DIVU:
  - Restoring division of magnitudes, one quotient bit per cycle.
  - DIV quotient truncates toward zero. Remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
- Most-negative ÷ −1 (DIV): lo = 0x80000000 (for WIDTH=32), hi = 0. No trap.
- Divide by zero:
  - RUN is skipped and the state goes IDLE→DONE directly.
  - hi/lo are unchanged; div_zero=1.
  - zero and negative are recomputed from the unchanged hi/lo.
- MTHI/MTLO:
  - IDLE→DONE directly. hi (or lo) = a; the other register is unchanged.
  - zero is recomputed; negative=0.
- Width rules:
  - Accumulator is 2·WIDTH bits; the divider partial remainder is WIDTH+1 bits.
  - Sign correction is two's-complement negate, modulo width.
- Reset (including mid-RUN):
  - State → IDLE.
  - hi=0, lo=0, busy=0, done=0, div_zero=0, zero=1, negative=0.
  - The in-flight result is discarded.

## Timing
- start sampled at the rising edge ending cycle t.
- Mul/div: busy=1 in cycles t+1..t+WIDTH. hi/lo/flags are written at the edge ending t+WIDTH. done=1 in cycle t+WIDTH+1, with busy=0.
- Divide by zero, MTHI, MTLO: done=1 in cycle t+1, with results visible.
- A start in a DONE cycle is accepted, so back-to-back ops run every WIDTH+1 cycles.
- A start while busy=1 is dropped; the op must be re-issued.
- hi/lo hold between operations. The old hi/lo stay visible during RUN until the final write.

## Structure
- Package muldiv_pkg holds:
  - op code localparams (OP_MULT..OP_MTLO)
  - state enum (IDLE, RUN, DONE)
  - function iter_bits(WIDTH) = $clog2(WIDTH+1) for the iteration counter
- Sub-module muldiv_abs, instantiated twice: WIDTH-bit value plus signed flag → magnitude and sign bit. It is reused for output negation.
- Top level holds the FSM, iteration counter, accumulator/remainder registers, HI/LO and flag registers.

## Test plan
- MULT a=0xFFFFFFFF, b=2 → done at t+33; hi=0xFFFFFFFF, lo=0xFFFFFFFE, negative=1.
- MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE, negative=0.
- DIV a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU b=0 after MTHI a=0x1234 and MTLO a=0 → done at t+1; div_zero=1; hi=0x1234, lo=0; zero=0.
- Stall/reset:
  - A start pulse at t+5 during MULT is ignored; the result still arrives at t+33.
  - rst at t+10 → busy=0, hi=lo=0, zero=1, and no done pulse.
  - A start in the DONE cycle is accepted.
